drive_gain: RTL and testbench

DRIVE_GAIN -- requirements
Module: drive_gain

---
 rtl/fxp_pkg.sv | 26 ++
 rtl/drive_gain_if.sv | 22 ++
 rtl/fxp_mul_sat.sv | 74 +++++++
 rtl/drive_gain.sv | 84 ++++++++
 tb/tb_drive_gain.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point types, saturation limits and the gain-ramp state enum
// used by the drive_gain block and its multiply/saturate datapath.
package fxp_pkg;

    localparam int FXP_SIZE_DEF       = 16;
    localparam int BITS_PER_LEVEL_DEF = 12;

    typedef logic signed [FXP_SIZE_DEF-1:0] sample_t;
    typedef logic        [FXP_SIZE_DEF-1:0] gain_t;

    typedef enum logic [1:0] {
        SETTLED   = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_e;

    // Largest and smallest representable signed values of a given width.
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/drive_gain_if.sv
// Sample/gain stream bundle between the sample source and drive_gain.
// The master side drives samples and target gain; the slave side is the gain stage.
interface drive_gain_if #(
    parameter int fxp_size = 16
);
    logic                       i_valid;
    logic signed [fxp_size-1:0] i_sample;
    logic        [fxp_size-1:0] i_gain;
    logic                       o_valid;
    logic signed [fxp_size-1:0] o_sample;
    logic                       o_settled;

    modport master (
        output i_valid, i_sample, i_gain,
        input  o_valid, o_sample, o_settled
    );

    modport slave (
        input  i_valid, i_sample, i_gain,
        output o_valid, o_sample, o_settled
    );
endinterface

// File: rtl/fxp_mul_sat.sv
// Two-stage signed x unsigned fixed-point multiply: stage 1 registers the full
// product, stage 2 registers the truncated, saturated result (held when idle).
module fxp_mul_sat
    import fxp_pkg::*;
#(
    parameter int bits_per_level = BITS_PER_LEVEL_DEF,
    parameter int fxp_size       = FXP_SIZE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [fxp_size-1:0] in_sample,
    input  logic        [fxp_size-1:0] in_gain,
    output logic                       out_valid,
    output logic signed [fxp_size-1:0] out_sample
);

    localparam int PW = 2 * fxp_size;
    localparam logic signed [PW-1:0] SAT_MAX = PW'(sat_max(fxp_size));
    localparam logic signed [PW-1:0] SAT_MIN = PW'(sat_min(fxp_size));

    logic signed [PW-1:0]       mul_a;
    logic signed [PW-1:0]       mul_b;
    logic signed [PW-1:0]       prod_d, prod_q;
    logic                       vld1_d, vld1_q;
    logic signed [PW-1:0]       shifted;
    logic signed [fxp_size-1:0] sample_d, sample_q;
    logic                       vld2_d, vld2_q;

    // The unsigned gain is zero-extended so the product of the widest operands
    // still fits in 2*fxp_size signed bits without wrap.
    always_comb begin
        mul_a  = PW'(in_sample);
        mul_b  = $signed(PW'(in_gain));
        prod_d = prod_q;
        if (in_valid) begin
            prod_d = mul_a * mul_b;
        end
        vld1_d = in_valid;
    end

    always_comb begin
        shifted  = prod_q >>> bits_per_level;
        sample_d = sample_q;
        if (vld1_q) begin
            if (shifted > SAT_MAX) begin
                sample_d = SAT_MAX[fxp_size-1:0];
            end else if (shifted < SAT_MIN) begin
                sample_d = SAT_MIN[fxp_size-1:0];
            end else begin
                sample_d = shifted[fxp_size-1:0];
            end
        end
        vld2_d = vld1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            vld1_q   <= 1'b0;
            sample_q <= '0;
            vld2_q   <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            vld1_q   <= vld1_d;
            sample_q <= sample_d;
            vld2_q   <= vld2_d;
        end
    end

    assign out_valid  = vld2_q;
    assign out_sample = sample_q;

endmodule

// File: rtl/drive_gain.sv
// Gain stage ahead of overdrive_clamp: applies cur_gain to each accepted sample.
// With DRIVE_GAIN_RAMP_EN defined cur_gain slews toward i_gain by ramp_step per sample.
module drive_gain
    import fxp_pkg::*;
#(
    parameter int bits_per_level = BITS_PER_LEVEL_DEF,
    parameter int fxp_size       = FXP_SIZE_DEF,
    parameter int ramp_step      = 16
) (
    input  logic       clk,
    input  logic       rst,
    drive_gain_if.slave bus
);

    localparam logic [fxp_size-1:0] UNITY = fxp_size'(1 << bits_per_level);

    ramp_state_e          state_d, state_q;
    logic [fxp_size-1:0]  cur_gain_d, cur_gain_q;

`ifdef DRIVE_GAIN_RAMP_EN
    localparam logic [fxp_size-1:0] STEP = fxp_size'(ramp_step);

    // Distances are taken only in the direction already known to be positive,
    // so neither the step nor the clamp can wrap.
    always_comb begin
        state_d    = state_q;
        cur_gain_d = cur_gain_q;
        if (bus.i_valid) begin
            if (cur_gain_q < bus.i_gain) begin
                state_d = RAMP_UP;
                if ((bus.i_gain - cur_gain_q) > STEP) begin
                    cur_gain_d = cur_gain_q + STEP;
                end else begin
                    cur_gain_d = bus.i_gain;
                end
            end else if (cur_gain_q > bus.i_gain) begin
                state_d = RAMP_DOWN;
                if ((cur_gain_q - bus.i_gain) > STEP) begin
                    cur_gain_d = cur_gain_q - STEP;
                end else begin
                    cur_gain_d = bus.i_gain;
                end
            end else begin
                state_d = SETTLED;
            end
        end
    end
`else
    always_comb begin
        state_d    = SETTLED;
        cur_gain_d = cur_gain_q;
        if (bus.i_valid) begin
            cur_gain_d = bus.i_gain;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SETTLED;
            cur_gain_q <= UNITY;
        end else begin
            state_q    <= state_d;
            cur_gain_q <= cur_gain_d;
        end
    end

    assign bus.o_settled = (state_q == SETTLED) && (cur_gain_q == bus.i_gain);

    // Each sample sees the gain held on its own acceptance cycle.
    fxp_mul_sat #(
        .bits_per_level (bits_per_level),
        .fxp_size       (fxp_size)
    ) u_mul_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (bus.i_valid),
        .in_sample  (bus.i_sample),
        .in_gain    (cur_gain_q),
        .out_valid  (bus.o_valid),
        .out_sample (bus.o_sample)
    );

endmodule

// File: tb/tb_drive_gain.sv
// Self-checking bench for drive_gain: directed cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_drive_gain;
    import fxp_pkg::*;

    localparam int BPL   = 12;
    localparam int W     = 16;
    localparam int STEP  = 16;
    localparam int UNITY = 1 << BPL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    drive_gain_if #(.fxp_size(W)) dg_if ();

    drive_gain #(
        .bits_per_level (BPL),
        .fxp_size       (W),
        .ramp_step      (STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dg_if)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int tgt    = UNITY;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: exact integer product, floor shift, clamp to the sample range.
    function automatic int gained(input int s, input int g);
        longint p;
        longint q;
        p = longint'(s) * longint'(g);
        q = p >>> BPL;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return (q < 0) ? int'(q + 65536) : int'(q);
    endfunction

    int m_gain    = UNITY;
    bit m_settled = 1'b1;
    bit p_v       = 1'b0;
    int p_s       = 0;
    bit e_v       = 1'b0;
    int e_s       = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gain    = UNITY;
            m_settled = 1'b1;
            p_v       = 1'b0;
            e_v       = 1'b0;
            e_s       = 0;
        end else begin
            int tg;
            tg  = int'(dg_if.i_gain);
            e_v = p_v;
            if (p_v) e_s = p_s;
            p_v = dg_if.i_valid;
            if (dg_if.i_valid) begin
                p_s = gained(int'($signed(dg_if.i_sample)), m_gain);
`ifdef DRIVE_GAIN_RAMP_EN
                if (tg > m_gain) begin
                    m_settled = 1'b0;
                    m_gain    = (m_gain + STEP < tg) ? m_gain + STEP : tg;
                end else if (tg < m_gain) begin
                    m_settled = 1'b0;
                    m_gain    = (m_gain - STEP > tg) ? m_gain - STEP : tg;
                end else begin
                    m_settled = 1'b1;
                end
`else
                m_gain    = tg;
                m_settled = 1'b1;
`endif
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("sb_o_valid", dg_if.o_valid, e_v);
        chk("sb_o_sample", $unsigned(dg_if.o_sample), e_s);
        chk("sb_o_settled", dg_if.o_settled, m_settled && (m_gain == int'(dg_if.i_gain)));
        chk("sb_cur_gain", dut.cur_gain_q, m_gain);
    end

    task automatic cyc(input bit v, input int s, input int g);
        @(negedge clk);
        dg_if.i_valid  = v;
        dg_if.i_sample = s[15:0];
        dg_if.i_gain   = g[15:0];
        @(posedge clk);
        #2;
    endtask

    task automatic settle(input int g);
        bit done;
        done = 1'b0;
        tgt  = g;
        for (int i = 0; i < 5000 && !done; i++) begin
            cyc(1'b1, 0, tgt);
            if (dg_if.o_settled) done = 1'b1;
        end
        chk("settle_reached", done, 1'b1);
        chk("settle_gain", dut.cur_gain_q, g);
        cyc(1'b0, 0, tgt);
        cyc(1'b0, 0, tgt);
    endtask

    task automatic xfer(input string tag, input int s, input int exp);
        cyc(1'b1, s, tgt);
        chk({tag, "_early"}, dg_if.o_valid, 1'b0);
        cyc(1'b0, 0, tgt);
        chk({tag, "_vld"}, dg_if.o_valid, 1'b1);
        chk(tag, $unsigned(dg_if.o_sample), exp);
    endtask

    initial begin
        int prev;
        int steps;
        dg_if.i_valid  = 1'b0;
        dg_if.i_sample = '0;
        dg_if.i_gain   = 16'(UNITY);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_valid", dg_if.o_valid, 1'b0);
        chk("rst_o_sample", $unsigned(dg_if.o_sample), 0);
        chk("rst_cur_gain", dut.cur_gain_q, UNITY);
        @(negedge clk);
        rst = 1'b0;

        xfer("unity", 'h0800, 'h0800);
        chk("unity_settled", dg_if.o_settled, 1'b1);

        settle('h4000);
        xfer("gain4_pos", 'h0800, 'h2000);
        xfer("gain4_neg", 'hF800, 'hE000);

        settle('hF000);
        xfer("sat_pos", 'h1000, 'h7FFF);
        xfer("sat_neg", 'hF000, 'h8000);

        settle('h1000);
`ifdef DRIVE_GAIN_RAMP_EN
        tgt   = 'h1100;
        steps = 0;
        prev  = int'(dut.cur_gain_q);
        for (int i = 0; i < 40 && !dg_if.o_settled; i++) begin
            cyc(1'b1, 0, tgt);
            if (int'(dut.cur_gain_q) != prev) begin
                chk("ramp_inc", int'(dut.cur_gain_q) - prev, STEP);
                chk("ramp_unsettled", dg_if.o_settled, 1'b0);
                steps++;
            end
            prev = int'(dut.cur_gain_q);
        end
        chk("ramp_steps", steps, 16);
        chk("ramp_final", dut.cur_gain_q, 'h1100);
        chk("ramp_settled", dg_if.o_settled, 1'b1);

        settle('h1000);
        tgt = 'h1008;
        cyc(1'b1, 0, tgt);
        chk("ramp_clamp", dut.cur_gain_q, 'h1008);

        settle('h1000);
        tgt = 'h1100;
        repeat (3) cyc(1'b1, 0, tgt);
        chk("rev_pre", dut.cur_gain_q, 'h1030);
        prev = int'(dut.cur_gain_q);
        tgt  = 'h0F00;
        cyc(1'b1, 0, tgt);
        chk("rev_step", prev - int'(dut.cur_gain_q), STEP);
`else
        tgt = 'h2345;
        cyc(1'b1, 0, tgt);
        chk("load_gain", dut.cur_gain_q, 'h2345);
        chk("load_settled", dg_if.o_settled, 1'b1);
`endif

        tgt = 'h2000;
        cyc(1'b1, 'h0400, tgt);
        cyc(1'b1, 'h0400, tgt);
        @(negedge clk);
        dg_if.i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_o_valid", dg_if.o_valid, 1'b0);
        chk("rstmid_cur_gain", dut.cur_gain_q, UNITY);
        chk("rstmid_o_sample", $unsigned(dg_if.o_sample), 0);
        @(negedge clk);
        rst = 1'b0;
        tgt = UNITY;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 0, tgt);
            chk("rstmid_stale", dg_if.o_valid, 1'b0);
        end

        cyc(1'b1, 'h0100, tgt);
        prev = int'(dut.cur_gain_q);
        cyc(1'b0, 0, tgt);
        chk("gap_idle_gain", dut.cur_gain_q, prev);
        chk("gap_v1", dg_if.o_valid, 1'b1);
        chk("gap_s1", $unsigned(dg_if.o_sample), 'h0100);
        cyc(1'b1, 'h0200, tgt);
        chk("gap_v0", dg_if.o_valid, 1'b0);
        chk("gap_hold", $unsigned(dg_if.o_sample), 'h0100);
        cyc(1'b0, 0, tgt);
        chk("gap_v2", dg_if.o_valid, 1'b1);
        chk("gap_s2", $unsigned(dg_if.o_sample), 'h0200);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0:       tgt = 'hFFFF;
                    1:       tgt = 0;
                    default: tgt = int'($urandom_range(0, 'h3000));
                endcase
            end
            cyc($urandom_range(0, 9) < 7, int'($urandom), tgt);
        end
        repeat (3) cyc(1'b0, 0, tgt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
